// File: rtl/kgp_alu.sv
// kgp_alu: 32-bit KGP-RISC execute-stage ALU; registered result/flags, one-cycle latency.
// Optional macro ALU_MUL_EN enables signed multiply on opcode 1100 (reserved otherwise).
module kgp_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             sign_flag,
  output logic             overflow_flag
);
  localparam int STAGES = 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_COMP = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SHLL = 4'b0100;
  localparam logic [3:0] OP_SHRL = 4'b0101;
  localparam logic [3:0] OP_SHRA = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
  localparam logic [3:0] OP_PASB = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;
  localparam logic [3:0] OP_SUB  = 4'b1111;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             c;
    logic             s;
    logic             v;
  } alu_rsp_t;

  logic [STAGES:0] vld_pipe;
  alu_rsp_t        rsp_d, rsp_q;

  // One shared adder: SUB/COMP feed ~b with carry-in 1, COMP forces a to 0.
  logic             is_sub, is_comp;
  logic [WIDTH-1:0] add_a, add_b;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [4:0]       sh;
  logic [WIDTH:0]   shl, shr, sra;

  assign is_comp = (opcode == OP_COMP);
  assign is_sub  = (opcode == OP_SUB) | is_comp;
  assign add_a   = is_comp ? '0 : a;
  assign add_b   = is_sub ? ~b : b;
  assign sum     = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf = (add_a[WIDTH-1] == add_b[WIDTH-1]) & (sum[WIDTH-1] != add_a[WIDTH-1]);

  // Extra bit on each shifter catches the last bit shifted out (0 for amount 0).
  assign sh  = b[4:0];
  assign shl = {1'b0, a} << sh;
  assign shr = {a, 1'b0} >> sh;
  assign sra = $signed({a, 1'b0}) >>> sh;

`ifdef ALU_MUL_EN
  logic signed [2*WIDTH-1:0] prod;
  assign prod = $signed(a) * $signed(b);
`endif

  always_comb begin
    rsp_d = '0;
    unique case (opcode)
      OP_ADD, OP_SUB, OP_COMP: begin
        rsp_d.res = sum[WIDTH-1:0];
        rsp_d.c   = sum[WIDTH];
        rsp_d.v   = add_ovf;
      end
      OP_AND:  rsp_d.res = a & b;
      OP_XOR:  rsp_d.res = a ^ b;
      OP_OR:   rsp_d.res = a | b;
      OP_NOR:  rsp_d.res = ~(a | b);
      OP_SHLL: begin
        rsp_d.res = shl[WIDTH-1:0];
        rsp_d.c   = shl[WIDTH];
      end
      OP_SHRL: begin
        rsp_d.res = shr[WIDTH:1];
        rsp_d.c   = shr[0];
      end
      OP_SHRA: begin
        rsp_d.res = sra[WIDTH:1];
        rsp_d.c   = sra[0];
      end
      OP_SLT:  rsp_d.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: rsp_d.res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASB: rsp_d.res = b;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        rsp_d.res = prod[WIDTH-1:0];
        rsp_d.v   = (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b0}}) &
                    (prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){1'b1}});
      end
`endif
      default: rsp_d = '0;
    endcase
    rsp_d.z = (rsp_d.res == '0);
    rsp_d.s = rsp_d.res[WIDTH-1];
  end

  assign vld_pipe[0] = valid_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      rsp_q              <= '{res: '0, z: 1'b1, c: 1'b0, s: 1'b0, v: 1'b0};
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (valid_in) rsp_q <= rsp_d;
    end
  end

  assign valid_out     = vld_pipe[STAGES];
  assign result        = rsp_q.res;
  assign zero_flag     = rsp_q.z;
  assign carry_flag    = rsp_q.c;
  assign sign_flag     = rsp_q.s;
  assign overflow_flag = rsp_q.v;
endmodule

// File: tb/tb_kgp_alu.sv
// tb_kgp_alu: directed spec vectors plus random ops, checked against a 64-bit arithmetic model.
module tb_kgp_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] a, b;
  logic [3:0]  opcode;
  logic        valid_out;
  logic [31:0] result;
  logic        zero_flag, carry_flag, sign_flag, overflow_flag;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q;

  kgp_alu dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .a(a), .b(b), .opcode(opcode),
    .valid_out(valid_out), .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .sign_flag(sign_flag), .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  function automatic logic out_of_range(input longint x);
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  // Returns {result, zero, carry, sign, overflow} from plain integer arithmetic.
  function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] x, y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    longint t;
    int     s = int'(y[4:0]);
    logic [31:0] r = '0;
    logic c = 1'b0, v = 1'b0;
    case (op)
      4'd0:  begin t = ux + uy; r = t[31:0]; c = t[32]; v = out_of_range(sx + sy); end
      4'd15: begin r = x - y; c = (ux >= uy); v = out_of_range(sx - sy); end
      4'd1:  begin r = 32'd0 - y; c = (uy == 0); v = out_of_range(-sy); end
      4'd2:  r = x & y;
      4'd3:  r = x ^ y;
      4'd7:  r = x | y;
      4'd8:  r = ~(x | y);
      4'd4:  begin r = x << s; c = (s != 0) ? x[32-s] : 1'b0; end
      4'd5:  begin r = x >> s; c = (s != 0) ? x[s-1] : 1'b0; end
      4'd6:  begin t = sx >>> s; r = t[31:0]; c = (s != 0) ? x[s-1] : 1'b0; end
      4'd9:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd10: r = (ux < uy) ? 32'd1 : 32'd0;
      4'd11: r = y;
`ifdef ALU_MUL_EN
      4'd12: begin t = sx * sy; r = t[31:0]; v = (t != longint'($signed(t[31:0]))); end
`endif
      default: r = '0;
    endcase
    return {r, (r == 32'd0), c, r[31], v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] dut_vec();
    return {result, zero_flag, carry_flag, sign_flag, overflow_flag};
  endfunction

  // Drive one op (or an idle cycle), advance one edge, compare against the model.
  task automatic issue(input string tag, input logic v, input logic [3:0] op,
                       input logic [31:0] x, input logic [31:0] y);
    valid_in = v; opcode = op; a = x; b = y;
    if (v) exp_q = ref_alu(op, x, y);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(valid_out), 64'(v));
    chk(tag, 64'(dut_vec()), 64'(exp_q));
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b1; opcode = 4'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    exp_q = {32'd0, 4'b1000};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 64'(valid_out), 64'd0);
    chk("rst_out", 64'(dut_vec()), 64'({32'd0, 4'b1000}));
    @(negedge clk);
    rst_n = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_vld", 64'(valid_out), 64'd0);
    chk("idle_out", 64'(dut_vec()), 64'({32'd0, 4'b1000}));

    // ADD back-to-back; flags are {zero,carry,sign,ovf}
    issue("add1", 1, 4'd0, 32'd10, -32'sd20);
    chk("add1_lit", 64'(dut_vec()), 64'({32'hFFFF_FFF6, 4'b0010}));
    issue("add2", 1, 4'd0, -32'sd10, -32'sd20);
    chk("add2_lit", 64'(dut_vec()), 64'({32'hFFFF_FFE2, 4'b0110}));
    issue("add3", 1, 4'd0, 32'h00A1_1A78, 32'h03AE_FF36);
    chk("add3_lit", 64'(dut_vec()), 64'({32'h0450_19AE, 4'b0000}));
    issue("add4", 1, 4'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add4_lit", 64'(dut_vec()), 64'({32'h8000_0000, 4'b0011}));

    issue("and1", 1, 4'd2, 32'd10, 32'd20);
    chk("and1_lit", 64'(dut_vec()), 64'({32'd0, 4'b1000}));
    issue("and2", 1, 4'd2, 32'd7, 32'hFFFF_FFFF);
    chk("and2_lit", 64'(result), 64'd7);
    issue("xor1", 1, 4'd3, 32'd7, 32'hFFFF_FFFF);
    chk("xor1_lit", 64'(dut_vec()), 64'({32'hFFFF_FFF8, 4'b0010}));

    issue("sub1", 1, 4'd15, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    chk("sub1_lit", 64'(dut_vec()), 64'({32'd0, 4'b1100}));
    issue("sub2", 1, 4'd15, 32'h8000_0000, 32'd1);
    chk("sub2_lit", 64'({result, overflow_flag}), 64'({32'h7FFF_FFFF, 1'b1}));
    issue("comp1", 1, 4'd1, 32'hDEAD_BEEF, 32'd5);
    chk("comp1_lit", 64'(result), 64'hFFFF_FFFB);

    issue("shra1", 1, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("shra1_lit", 64'({result, carry_flag}), 64'({32'hFFFF_FFFF, 1'b1}));
    issue("shrl1", 1, 4'd5, 32'h8000_0000, 32'd31);
    chk("shrl1_lit", 64'(result), 64'd1);
    issue("shll1", 1, 4'd4, 32'd1, 32'd0);
    chk("shll1_lit", 64'({result, carry_flag}), 64'({32'd1, 1'b0}));

    issue("gap", 0, 4'd0, 32'd99, 32'd1);
    chk("gap_hold", 64'(result), 64'd1);
    issue("rsv13", 1, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("rsv13_lit", 64'(dut_vec()), 64'({32'd0, 4'b1000}));
    issue("slt", 1, 4'd9, -32'sd3, 32'd2);
    issue("sltu", 1, 4'd10, -32'sd3, 32'd2);

    // Async reset between edges must clear immediately
    issue("pre_rst", 1, 4'd11, 32'd0, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 64'(valid_out), 64'd0);
    chk("async_rst_out", 64'(dut_vec()), 64'({32'd0, 4'b1000}));
    exp_q = {32'd0, 4'b1000};
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'd0;
      issue("rand", ($urandom_range(0, 5) != 0), 4'($urandom_range(0, 15)), ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
